// File: rtl/cnt_pkg.sv
// Shared constants for the counter sequencing controller:
// FSM state encodings, direction codes and default widths.
package cnt_pkg;

  localparam int N_DEF = 4;
  localparam int R_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/cnt_rep_tracker.sv
// Remaining-periods register: loads on start/reload,
// decrements on timeout, saturates at zero.
module cnt_rep_tracker #(
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         load,
  input  logic [R-1:0] load_val,
  input  logic         dec,
  output logic [R-1:0] rep_left,
  output logic         last_rep
);

  localparam logic [R-1:0] ONE = R'(1);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rep_left <= '0;
    end else if (load) begin
      rep_left <= load_val;
    end else if (dec && rep_left != '0) begin
      rep_left <= rep_left - ONE;
    end
  end

  assign last_rep = (rep_left == ONE);

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequencing controller for the up/down timeout counter.
// Optional auto-reload via macro CNT_SEQ_AUTO_RELOAD_EN.
module cnt_seq_ctrl
  import cnt_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  input  logic         stop,
  input  logic         dir,
  input  logic [R-1:0] reps,
`ifdef CNT_SEQ_AUTO_RELOAD_EN
  input  logic         auto_reload,
`endif
  output logic         busy,
  output logic         done,
  output logic         aborted,
  output logic [R-1:0] rep_left,
  output logic         cnt_enable,
  output logic         cnt_dn_up,
  output logic         cnt_clr_n,
  input  logic         cnt_timeout
);

  // N belongs to the counter; kept only so both share one parameter set.
  logic unused_n;
  assign unused_n = ^N;

  logic [1:0]   state;
  logic [1:0]   state_nx;
  logic         ab_nx;
  logic         load;
  logic         dec;
  logic [R-1:0] load_val;
  logic         last_rep;
  logic         dir_q;

`ifdef CNT_SEQ_AUTO_RELOAD_EN
  logic         auto_q;
  logic [R-1:0] reps_q;
`endif

  cnt_rep_tracker #(.R(R)) u_rep (
    .clk      (clk),
    .n_reset  (n_reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .rep_left (rep_left),
    .last_rep (last_rep)
  );

  always_comb begin
    state_nx = state;
    ab_nx    = 1'b0;
    load     = 1'b0;
    dec      = 1'b0;
    load_val = reps;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = (reps != '0) ? ST_CLR : ST_DONE;
        end
      end
      ST_CLR: state_nx = ST_RUN;
      ST_RUN: begin
        dec = cnt_timeout;
        // Final timeout wins over a coincident stop.
        if (cnt_timeout && last_rep) begin
          state_nx = ST_DONE;
        end else if (stop) begin
          state_nx = ST_DONE;
          ab_nx    = 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
`ifdef CNT_SEQ_AUTO_RELOAD_EN
        if (auto_q && !aborted && reps_q != '0) begin
          state_nx = ST_CLR;
          load     = 1'b1;
          load_val = reps_q;
        end
`endif
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_clr_n  <= 1'b1;
      dir_q      <= DIR_DN;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != ST_IDLE);
      done       <= (state_nx == ST_DONE);
      aborted    <= (state_nx == ST_DONE) && ab_nx;
      cnt_enable <= (state_nx == ST_RUN);
      cnt_clr_n  <= (state_nx != ST_CLR);
      if (state == ST_IDLE && start) begin
        dir_q <= dir;
      end
    end
  end

`ifdef CNT_SEQ_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      auto_q <= 1'b0;
      reps_q <= '0;
    end else if (state == ST_IDLE && start) begin
      auto_q <= auto_reload;
      reps_q <= reps;
    end
  end
`endif

  assign cnt_dn_up = dir_q;

endmodule
